// File: rtl/conv_sa_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_sa_ctrl_pkg                                       |
// | Description : Shared constants, FSM state codes and tap-order        |
// |               indices for the systolic-array convolution controller. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package conv_sa_ctrl_pkg;

   // Default datapath and timing constants
   localparam int N      = 8;    // element width
   localparam int TAPS   = 9;    // taps per filter (3x3)
   localparam int LAT    = 10;   // accept edge to engine result sample edge
   localparam int HOLD   = 9;    // cycles a window is held on the engine
   localparam int FDEPTH = 4;    // result FIFO depth

   // Controller states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_W = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Engine tap order: index 0 sits in the LSBs of eng_W / eng_G
   localparam int TAP_00 = 0;
   localparam int TAP_01 = 1;
   localparam int TAP_02 = 2;
   localparam int TAP_03 = 3;
   localparam int TAP_10 = 4;
   localparam int TAP_11 = 5;
   localparam int TAP_12 = 6;
   localparam int TAP_13 = 7;
   localparam int TAP_14 = 8;

endpackage
`default_nettype wire

// File: rtl/conv_sa_ctrl_res_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_res_fifo                                          |
// | Description : Synchronous result FIFO with occupancy count, full and |
// |               empty flags. Simultaneous push and pop both honoured.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module conv_res_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is accepted only when a pop frees the slot
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage and pointers; depth is a power of two so pointers wrap naturally
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy tracking
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   // The controller's credit check must never let a push hit a full FIFO
   a_no_overflow : assert property (@(posedge Clk) disable iff (!Rst_n)
                                    !(push && full && !pop));
`endif

endmodule
`default_nettype wire

// File: rtl/conv_sa_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_sa_ctrl                                           |
// | Description : Job controller for a 3x3 systolic-array convolution    |
// |               engine: loads filter taps, paces windows into the      |
// |               engine, and collects its results into a FIFO.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module conv_sa_ctrl #(
   parameter int N      = conv_sa_ctrl_pkg::N,
   parameter int LAT    = conv_sa_ctrl_pkg::LAT,
   parameter int HOLD   = conv_sa_ctrl_pkg::HOLD,
   parameter int FDEPTH = conv_sa_ctrl_pkg::FDEPTH
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             start,
   input  logic [15:0]      num_win,
   output logic             busy,
   output logic             done,
   input  logic             wt_valid,
   output logic             wt_ready,
   input  logic [N-1:0]     wt_w,
   input  logic [N-1:0]     wt_g,
   input  logic             win_valid,
   output logic             win_ready,
   input  logic [9*N-1:0]   win_data,
   output logic             eng_compute_SA,
   output logic [9*N-1:0]   eng_F,
   output logic [9*N-1:0]   eng_W,
   output logic [9*N-1:0]   eng_G,
   input  logic [2*N-1:0]   eng_C1,
   input  logic [2*N-1:0]   eng_C2,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [4*N-1:0]   res_data
);

   import conv_sa_ctrl_pkg::*;

   localparam int BCW = $clog2(TAPS + 1);
   localparam int HCW = $clog2(HOLD + 1);
   localparam int IFW = $clog2(LAT + 1);
   localparam int FCW = $clog2(FDEPTH) + 1;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [15:0]      remaining;
   logic [BCW-1:0]   beat_cnt;
   logic [HCW-1:0]   hold_cnt;
   logic [LAT-1:0]   vld_pipe;
   logic [IFW-1:0]   in_flight;
   logic [9*N-1:0]   tap_w;
   logic [9*N-1:0]   tap_g;
   logic [FCW-1:0]   fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wt_accept;
   logic             win_accept;
   logic             last_beat;
   logic             credit_ok;
   logic             push;
   logic             pop;

   // Handshake and status decode
   assign busy           = (state != ST_IDLE);
   assign done           = (state == ST_DONE);
   assign wt_ready       = (state == ST_LOAD_W);
   assign eng_compute_SA = (state == ST_RUN) || (state == ST_DRAIN);
   // Windows already in the engine plus results waiting must fit in the FIFO
   assign credit_ok      = (int'(in_flight) + int'(fifo_count)) < FDEPTH;
   assign win_ready      = (state == ST_RUN) && (remaining != '0) &&
                           (hold_cnt == '0) && credit_ok && !fifo_full;
   assign wt_accept      = wt_valid && wt_ready;
   assign win_accept     = win_valid && win_ready;
   assign last_beat      = (beat_cnt == BCW'(TAP_14));
   assign push           = vld_pipe[LAT-1];
   assign pop            = res_valid && res_ready;
   assign res_valid      = !fifo_empty;
   assign eng_W          = tap_w;
   assign eng_G          = tap_g;

   // Next-state logic for the job sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
         ST_LOAD_W: if (wt_accept && last_beat)
                       state_nxt = (remaining == '0) ? ST_DRAIN : ST_RUN;
         ST_RUN:    if ((remaining == '0) || (win_accept && remaining == 16'd1))
                       state_nxt = ST_DRAIN;
         ST_DRAIN:  if ((in_flight == '0) && fifo_empty) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State, job counters and window hold timer
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         beat_cnt  <= BCW'(TAP_00);
         hold_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE) begin
            if (start) remaining <= num_win;
            beat_cnt <= BCW'(TAP_00);
            hold_cnt <= '0;
         end else begin
            if (wt_accept) beat_cnt <= beat_cnt + BCW'(1);
            if (win_accept) begin
               remaining <= remaining - 16'd1;
               hold_cnt  <= HCW'(HOLD - 1);
            end else if (hold_cnt != '0) begin
               hold_cnt <= hold_cnt - HCW'(1);
            end
         end
      end
   end

   // Tap registers: written one beat at a time, only while loading weights
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tap_w <= '0;
         tap_g <= '0;
      end else if (wt_accept) begin
         tap_w[beat_cnt*N +: N] <= wt_w;
         tap_g[beat_cnt*N +: N] <= wt_g;
      end
   end

   // Feature window register held on the engine until the next accept
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)          eng_F <= '0;
      else if (win_accept) eng_F <= win_data;
   end

   // Result-valid shift line mirroring engine latency, plus occupancy count
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld_pipe  <= '0;
         in_flight <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[LAT-2:0], win_accept};
         in_flight <= in_flight + IFW'(win_accept) - IFW'(push);
      end
   end

   conv_res_fifo #(
      .WIDTH (4*N),
      .DEPTH (FDEPTH)
   ) u_res_fifo (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .push      (push),
      .push_data ({eng_C2, eng_C1}),
      .pop       (pop),
      .pop_data  (res_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_conv_sa_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_conv_sa_ctrl                                        |
// | Description : Scoreboard testbench for conv_sa_ctrl with a delayed   |
// |               dot-product engine model.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_conv_sa_ctrl;

   localparam int N      = 8;
   localparam int LAT    = 10;
   localparam int HOLD   = 9;
   localparam int FDEPTH = 4;

   logic            Clk = 1'b0;
   logic            Rst_n = 1'b0;
   logic            start = 1'b0;
   logic [15:0]     num_win = '0;
   logic            busy, done;
   logic            wt_valid = 1'b0;
   logic            wt_ready;
   logic [N-1:0]    wt_w = '0, wt_g = '0;
   logic            win_valid = 1'b0;
   logic            win_ready;
   logic [9*N-1:0]  win_data = '0;
   logic            eng_compute_SA;
   logic [9*N-1:0]  eng_F, eng_W, eng_G;
   logic [2*N-1:0]  eng_C1, eng_C2;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic [4*N-1:0]  res_data;

   conv_sa_ctrl #(.N(N), .LAT(LAT), .HOLD(HOLD), .FDEPTH(FDEPTH)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .start(start), .num_win(num_win),
      .busy(busy), .done(done),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_w(wt_w), .wt_g(wt_g),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .eng_compute_SA(eng_compute_SA), .eng_F(eng_F), .eng_W(eng_W), .eng_G(eng_G),
      .eng_C1(eng_C1), .eng_C2(eng_C2),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int res_seen = 0;
   int comp_cnt = 0;
   int done_cnt = 0;
   logic [4*N-1:0] exp_q[$];

   // Free-running cycle counter
   always @(posedge Clk) cyc <= cyc + 1;

   // Engine model: dot products delayed so the value sampled at accept+LAT
   // belongs to the window accepted at that edge
   logic [2*N-1:0] pc1 [9];
   logic [2*N-1:0] pc2 [9];

   function automatic logic [2*N-1:0] dot(input logic [9*N-1:0] f,
                                          input logic [9*N-1:0] c);
      int acc, a, b;
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         a = int'($signed(f[i*N +: N]));
         b = int'($signed(c[i*N +: N]));
         acc += a * b;
      end
      return acc[2*N-1:0];
   endfunction

   always @(posedge Clk) begin
      pc1[0] <= dot(eng_F, eng_W);
      pc2[0] <= dot(eng_F, eng_G);
      for (int i = 1; i < 9; i++) begin
         pc1[i] <= pc1[i-1];
         pc2[i] <= pc2[i-1];
      end
   end
   assign eng_C1 = pc1[8];
   assign eng_C2 = pc2[8];

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // Monitor: pops the scoreboard on every result handshake
   initial begin
      forever begin
         @(negedge Clk);
         if (Rst_n) begin
            if (eng_compute_SA) comp_cnt++;
            if (done) done_cnt++;
            if (res_valid) res_seen++;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL res_unexpected: got %0h expected none", res_data);
               end else begin
                  check("res_data", res_data, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start   = 1'b1;
      num_win = 16'(n);
      tick();
      start   = 1'b0;
   endtask

   task automatic load_weights(input logic [N-1:0] w, input logic [N-1:0] g);
      for (int i = 0; i < 9; i++) begin
         int t;
         t = 0;
         wt_valid = 1'b1;
         wt_w = w;
         wt_g = g;
         @(negedge Clk);
         while (!wt_ready && t < 50) begin
            @(negedge Clk);
            t++;
         end
         if (!wt_ready) fail_timeout("wt_beat");
         tick();
         wt_valid = 1'b0;
      end
   endtask

   task automatic send_window(input logic [9*N-1:0] data,
                              input logic [4*N-1:0] exp, output int acc_cyc);
      int t;
      t = 0;
      acc_cyc = -1;
      win_valid = 1'b1;
      win_data  = data;
      @(negedge Clk);
      while (!win_ready && t < 300) begin
         @(negedge Clk);
         t++;
      end
      if (!win_ready) begin
         fail_timeout("win_accept");
         win_valid = 1'b0;
      end else begin
         tick();
         acc_cyc = cyc;
         exp_q.push_back(exp);
         win_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      @(negedge Clk);
      while (!done && t < 300) begin
         @(negedge Clk);
         t++;
      end
      check({tag, "_done"}, done, 1'b1);
      @(negedge Clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      tick();
   endtask

   function automatic logic [9*N-1:0] win_seq();
      logic [9*N-1:0] w;
      for (int i = 0; i < 9; i++) w[i*N +: N] = N'(i + 1);
      return w;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, {busy, done, wt_ready, win_ready, res_valid, eng_compute_SA}, 6'b0);
      check({tag, "_engF"}, eng_F, 72'h0);
      check({tag, "_engW"}, eng_W, 72'h0);
      check({tag, "_engG"}, eng_G, 72'h0);
      check({tag, "_res_data"}, res_data, 32'h0);
   endtask

   initial begin
      int e0, e1, e2, snap, wr_hi, acc_n;

      // Reset state
      repeat (2) @(negedge Clk);
      check_reset_outputs("rst");
      tick();
      Rst_n = 1'b1;
      tick();

      // Basic result and latency
      do_start(1);
      check("t1_busy", busy, 1'b1);
      load_weights(8'd1, 8'd2);
      check("t1_engW", eng_W, {9{8'd1}});
      check("t1_engG", eng_G, {9{8'd2}});
      send_window(win_seq(), {16'd90, 16'd45}, e0);
      begin
         int t;
         t = 0;
         @(negedge Clk);
         while (!res_valid && t < 40) begin
            @(negedge Clk);
            t++;
         end
         check("t1_latency", cyc - e0, LAT);
      end
      wait_done("t1");
      check("t1_q_empty", exp_q.size(), 0);

      // Signed pass-through
      do_start(1);
      load_weights(8'd5, 8'hFF);
      send_window({9{8'hFD}}, {16'd27, 16'hFF79}, e0);
      wait_done("t2");
      check("t2_q_empty", exp_q.size(), 0);

      // Back-to-back windows with a stray start in RUN
      do_start(3);
      load_weights(8'd1, 8'd2);
      send_window({9{8'd1}}, {16'd18, 16'd9}, e0);
      start = 1'b1;
      num_win = 16'd5;
      tick();
      start = 1'b0;
      send_window({9{8'd2}}, {16'd36, 16'd18}, e1);
      send_window({9{8'd3}}, {16'd54, 16'd27}, e2);
      check("t3_spacing1", e1 - e0, HOLD);
      check("t3_spacing2", e2 - e1, HOLD);
      wait_done("t3");
      repeat (3) tick();
      check("t3_start_ignored", busy, 1'b0);
      check("t3_q_empty", exp_q.size(), 0);

      // Zero-window job
      do_start(0);
      comp_cnt = 0;
      res_seen = 0;
      load_weights(8'd1, 8'd1);
      wait_done("t4");
      check("t4_compute_le1", (comp_cnt <= 1), 1'b1);
      check("t4_no_res", res_seen, 0);

      // Backpressure: only FDEPTH windows accepted while results are stalled
      res_ready = 1'b0;
      acc_n = 0;
      do_start(8);
      load_weights(8'd1, 8'd2);
      fork
         begin
            for (int j = 1; j <= 8; j++) begin
               int ec;
               send_window({9{8'(j)}}, {16'(18 * j), 16'(9 * j)}, ec);
               if (ec >= 0) acc_n++;
            end
         end
      join_none
      repeat (60) tick();
      wr_hi = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (win_ready) wr_hi++;
      end
      check("t5_accepts", acc_n, 4);
      check("t5_ready_low", wr_hi, 0);
      check("t5_res_valid", res_valid, 1'b1);
      tick();
      res_ready = 1'b1;
      wait fork;
      check("t5_all_accepted", acc_n, 8);
      wait_done("t5");
      check("t5_q_empty", exp_q.size(), 0);

      // Mid-job reset with two windows in flight
      do_start(4);
      load_weights(8'd1, 8'd2);
      send_window({9{8'd3}}, {16'd54, 16'd27}, e0);
      send_window({9{8'd4}}, {16'd72, 16'd36}, e1);
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      exp_q.delete();
      snap = done_cnt;
      tick();
      tick();
      Rst_n = 1'b1;
      res_seen = 0;
      repeat (20) tick();
      check("t6_no_stale", res_seen, 0);
      check("t6_no_done", done_cnt, snap);
      do_start(1);
      load_weights(8'd2, 8'd1);
      send_window(win_seq(), {16'd45, 16'd90}, e0);
      wait_done("t6");
      check("t6_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_sa_ctrl.md
CONV_SA_CTRL -- requirements
Module: conv_sa_ctrl

Interface
REQ-001 Parameter N, default 8: feature/weight element width in bits.
REQ-002 Parameter LAT, default 10: cycles from window accept edge to engine result sample edge.
REQ-003 Parameter HOLD, default 9: cycles each window is held on eng_F; minimum accept spacing.
REQ-004 Parameter FDEPTH, default 4: result FIFO depth, power of two.
REQ-005 Clk  input  1  clock; all state on rising edge.
REQ-006 Rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle job start pulse; sampled only in IDLE.
REQ-008 num_win  input  16  windows in job; latched on start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse at job completion.
REQ-011 wt_valid / wt_ready  input / output  1 / 1  weight-beat handshake.
REQ-012 wt_w, wt_g  input  N each  W-filter and G-filter coefficients for one tap.
REQ-013 win_valid / win_ready  input / output  1 / 1  window handshake.
REQ-014 win_data  input  9N  3x3 window; F1 in [N-1:0] through F9 in [9N-1:8N].
REQ-015 eng_compute_SA  output  1  engine enable.
REQ-016 eng_F, eng_W, eng_G  output  9N each  engine feature, W-filter and G-filter taps; tap 0 in LSBs, order W00,W01,W02,W03,W10..W14 (likewise G).
REQ-017 eng_C1, eng_C2  input  2N each  engine results, signed.
REQ-018 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-019 res_data  output  4N  {C2,C1}; C1 in the LSBs.

Function
REQ-020 States: IDLE, LOAD_W, RUN, DRAIN, DONE.
REQ-021 IDLE->LOAD_W on start; start while busy is ignored.
REQ-022 LOAD_W: wt_ready=1; accept exactly 9 beats into tap registers 0..8 in order; ->RUN after beat 9.
REQ-023 RUN: accept windows until num_win have been accepted; ->DRAIN on the accept edge of the last window, or immediately if num_win=0.
REQ-024 win_ready=1 only in RUN when remaining>0, the hold counter has expired (>=HOLD cycles since the last accept), and in_flight+fifo_count<FDEPTH.
REQ-025 On each accept, eng_F is loaded from win_data and held until the next accept.
REQ-026 Tap registers drive eng_W/eng_G continuously and change only in LOAD_W.
REQ-027 eng_compute_SA=1 in RUN and DRAIN, 0 otherwise.
REQ-028 A valid shift pipeline of depth LAT pushes {eng_C2,eng_C1} into the FIFO on edge k+LAT for a window accepted on edge k; in_flight counts pipeline occupancy.
REQ-029 Results are pass-through, with no saturation or rounding; 2N-bit values are copied bit-exact.
REQ-030 FIFO order is strict first-in first-out; pop on res_valid&&res_ready; push and pop in the same cycle are both honoured.
REQ-031 The credit rule in REQ-024 guarantees a push never meets a full FIFO; an overflow is a design error and shall be asserted.
REQ-032 DRAIN->DONE when in_flight=0 and FIFO is empty.
REQ-033 DONE asserts done for one cycle, then ->IDLE.
REQ-034 win_data and wt_* are ignored outside their accepting states.

Reset
REQ-035 Rst_n low asynchronously forces the following:
- IDLE state; all counters, pipeline and FIFO cleared;
- eng_F, tap registers and res_data set to 0;
- busy, done, wt_ready, win_ready, res_valid and eng_compute_SA set to 0.
REQ-036 Reset mid-job discards all in-flight results; no done is issued for the aborted job.

Structure
REQ-037 Shared package holds: the state enumeration; constants N=8, TAPS=9, LAT=10, HOLD=9, FDEPTH=4; the tap-order index constants.
REQ-038 One sub-module, conv_res_fifo: synchronous FIFO with width 4N and depth FDEPTH, reporting count, full and empty.

Verification
REQ-039 Basic result:
- Stimulus: W taps all 1, G taps all 2, one window F=1..9, res_ready=1.
- Response: res_data C1=45, C2=90, valid starting cycle k+LAT+1; done follows.
REQ-040 Signed values:
- Stimulus: W all 5, G all -1, F all -3.
- Response: C1=-135 (0xFF79), C2=27.
REQ-041 Backpressure:
- Stimulus: num_win=8, res_ready=0.
- Response: win_ready stays low after 4 accepts; releasing res_ready lets all 8 results drain in order; then done.
REQ-042 num_win=0:
- Stimulus: start with num_win=0, then 9 weight beats.
- Response: done occurs with no res_valid; eng_compute_SA is asserted for at most one cycle.
REQ-043 Ignored start and spacing:
- Stimulus: start pulse in RUN; back-to-back win_valid.
- Response: the start is ignored; accepts are spaced exactly HOLD cycles apart.
REQ-044 Mid-job reset:
- Stimulus: Rst_n low with 2 windows in flight.
- Response: all outputs at reset values; no stale results after restart.
